// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-share arbiter: FSM state encodings
// and the default WAIT-cycle limit used when MULT_ARB_TIMEOUT_EN is defined.
package mult_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Default WAIT limit: a full shift-add pass over 2*WIDTH bits plus slack.
  function automatic int default_timeout(input int width);
    return 2 * width + 8;
  endfunction

endpackage

// File: rtl/rr_arbiter_taint.sv
// Combinational round-robin pick with a 1-bit taint summary.
// The search starts at ptr and wraps; gt is the OR of the taint of every
// active request, because the identity of the winner depends on all of them.
module rr_arbiter_taint
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_t,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] index,
  output logic            any,
  output logic            gt
);

  // First active request at or after ptr, wrapping around.
  always_comb begin
    int j;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    gt     = |(req & req_t);
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        index     = IDXW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier_share_arbiter_taint.sv
// Shares one taint-tracking sequential multiplier among NREQ requesters.
// Round-robin grant, operand capture, single start pulse, done wait, result
// return; 1-bit taint is carried conservatively on every data/control path.
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT
// cycles and flag rsp_err; otherwise WAIT is unbounded and rsp_err is 0.
//
// state | meaning
// IDLE  | no transaction; arbitrate among active requests
// ISSUE | gnt and m_start pulse, operands presented to the multiplier
// WAIT  | waiting for m_done; first cycle ignores a stale done
// RESP  | rsp_valid pulse to the winner, result from capture register
module multiplier_share_arbiter_taint
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = default_timeout(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_t,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ-1:0]         req_a_t,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_b_t,
  output logic [NREQ-1:0]         gnt,
  output logic                    gnt_t,
  output logic [NREQ-1:0]         rsp_valid,
  output logic                    rsp_valid_t,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_product_t,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    m_start,
  output logic                    m_start_t,
  output logic [WIDTH-1:0]        m_multiplier,
  output logic                    m_multiplier_t,
  output logic [WIDTH-1:0]        m_multiplicand,
  output logic                    m_multiplicand_t,
  input  logic [2*WIDTH-1:0]      m_product,
  input  logic                    m_product_t,
  input  logic                    m_done,
  input  logic                    m_done_t
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]         state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]    win_oh_q, win_oh_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               at_q, at_d, bt_q, bt_d;
  logic               gt_q, gt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               prod_t_q, prod_t_d;
  logic               vt_q, vt_d;
  logic               wait2_q, wait2_d;

  logic [NREQ-1:0]    arb_onehot;
  logic [IDXW-1:0]    arb_index;
  logic               arb_any;
  logic               arb_gt;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               err_q, err_d;
`else
  logic               unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  rr_arbiter_taint #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req    (req),
    .req_t  (req_t),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .index  (arb_index),
    .any    (arb_any),
    .gt     (arb_gt)
  );

  // Next-state and capture logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_oh_d = win_oh_q;
    a_d      = a_q;
    b_d      = b_q;
    at_d     = at_q;
    bt_d     = bt_q;
    gt_d     = gt_q;
    prod_d   = prod_q;
    prod_t_d = prod_t_q;
    vt_d     = vt_q;
    wait2_d  = wait2_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d  = ST_ISSUE;
          win_oh_d = arb_onehot;
          a_d      = req_a[arb_index*WIDTH +: WIDTH];
          b_d      = req_b[arb_index*WIDTH +: WIDTH];
          at_d     = req_a_t[arb_index];
          bt_d     = req_b_t[arb_index];
          gt_d     = arb_gt;
          ptr_d    = (int'(arb_index) == NREQ - 1) ? '0 : arb_index + IDXW'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wait2_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        wait2_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + CNTW'(1);
`endif
        // A done still high from the previous operation is ignored on the
        // first WAIT cycle; the multiplier has only just seen m_start.
        if (wait2_q && m_done) begin
          state_d  = ST_RESP;
          prod_d   = m_product;
          prod_t_d = m_product_t | gt_q;
          vt_d     = m_done_t | gt_q;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q == CNTW'(TIMEOUT)) begin
          state_d  = ST_RESP;
          prod_d   = '0;
          prod_t_d = gt_q;
          vt_d     = gt_q;
          err_d    = 1'b1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_oh_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      at_q     <= 1'b0;
      bt_q     <= 1'b0;
      gt_q     <= 1'b0;
      prod_q   <= '0;
      prod_t_q <= 1'b0;
      vt_q     <= 1'b0;
      wait2_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_oh_q <= win_oh_d;
      a_q      <= a_d;
      b_q      <= b_d;
      at_q     <= at_d;
      bt_q     <= bt_d;
      gt_q     <= gt_d;
      prod_q   <= prod_d;
      prod_t_q <= prod_t_d;
      vt_q     <= vt_d;
      wait2_q  <= wait2_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign gnt              = (state_q == ST_ISSUE) ? win_oh_q : '0;
  assign gnt_t            = (state_q == ST_ISSUE) & gt_q;
  assign m_start          = (state_q == ST_ISSUE);
  assign m_start_t        = (state_q == ST_ISSUE) & gt_q;
  assign m_multiplier     = a_q;
  assign m_multiplier_t   = at_q | gt_q;
  assign m_multiplicand   = b_q;
  assign m_multiplicand_t = bt_q | gt_q;
  assign rsp_valid        = (state_q == ST_RESP) ? win_oh_q : '0;
  assign rsp_valid_t      = (state_q == ST_RESP) & vt_q;
  assign rsp_product      = prod_q;
  assign rsp_product_t    = prod_t_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign rsp_err          = (state_q == ST_RESP) & err_q;
`else
  assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_share_arbiter_taint.sv
// Self-checking bench for multiplier_share_arbiter_taint. Requesters and the
// shared multiplier are behavioural models; the scoreboard derives each
// transaction's timeline (grant, qualifying done, response) from cycle numbers.
module tb_multiplier_share_arbiter_taint;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 2 * WIDTH + 8;
  localparam int NEVER   = 32'h7fff_ffff;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, req_t, req_a_t, req_b_t;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       gnt, rsp_valid;
  logic                  gnt_t, rsp_valid_t, rsp_product_t, rsp_err, busy;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  m_start, m_start_t, m_multiplier_t, m_multiplicand_t;
  logic [WIDTH-1:0]      m_multiplier, m_multiplicand;
  logic [2*WIDTH-1:0]    m_product;
  logic                  m_product_t, m_done, m_done_t;

  always #5 clk = ~clk;

  multiplier_share_arbiter_taint #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_t(req_t), .req_a(req_a), .req_a_t(req_a_t),
    .req_b(req_b), .req_b_t(req_b_t),
    .gnt(gnt), .gnt_t(gnt_t), .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t),
    .rsp_product(rsp_product), .rsp_product_t(rsp_product_t), .rsp_err(rsp_err),
    .busy(busy), .m_start(m_start), .m_start_t(m_start_t),
    .m_multiplier(m_multiplier), .m_multiplier_t(m_multiplier_t),
    .m_multiplicand(m_multiplicand), .m_multiplicand_t(m_multiplicand_t),
    .m_product(m_product), .m_product_t(m_product_t),
    .m_done(m_done), .m_done_t(m_done_t)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // requester models
  logic [NREQ-1:0]  rq = '0, rq_t = '0, ra_t = '0, rb_t = '0;
  logic [WIDTH-1:0] ra [NREQ];
  logic [WIDTH-1:0] rb [NREQ];

  // stimulus configuration
  int   gen_mode    = 0;   // 0 directed, 1 random, 2 all requesters always asking
  bit   withdraw_en = 0;
  int   cfg_d       = 3;   // multiplier latency in cycles after start, 0 = random
  bit   cfg_stuck   = 0;
  bit   cfg_dt_rand = 0;
  logic rst_drv     = 1'b0;

  // scoreboard: the one outstanding transaction
  bit               tx_valid = 0;
  int               tx_s, tx_r, tx_w, tx_d;
  bit               tx_gt, tx_at, tx_bt, tx_dt, tx_stuck;
  logic [WIDTH-1:0] tx_a, tx_b;
  int               ptr_m = 0;
  int               hold_cyc = -1;
  logic [63:0]      hold_val;
  int               gnt_log [$];

  // multiplier model
  bit               op_valid = 0, op_stuck = 0;
  int               op_s = 0, op_d = 1;
  logic [63:0]      op_prod = '0;
  bit               op_t = 0, op_dt = 0;
  bit               last_done = 0, last_t = 0, last_dt = 0;
  logic [63:0]      last_prod = '0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic arm(input int i, input bit rnd_taint);
    rq[i] = 1'b1;
    ra[i] = WIDTH'($urandom);
    rb[i] = WIDTH'($urandom);
    rq_t[i] = rnd_taint && ($urandom_range(0, 5) == 0);
    ra_t[i] = rnd_taint && ($urandom_range(0, 5) == 0);
    rb_t[i] = rnd_taint && ($urandom_range(0, 5) == 0);
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit rt, input bit at, input bit bt);
    rq[i] = 1'b1; ra[i] = a; rb[i] = b; rq_t[i] = rt; ra_t[i] = at; rb_t[i] = bt;
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic tick();
    int          k, w, qual;
    bit          issue_c, resp_c, exp_busy;
    logic [63:0] exp_p;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (gen_mode == 1) begin
        if (!rq[i]) begin
          if ($urandom_range(0, 3) == 0) arm(i, 1'b1);
        end else if (withdraw_en && $urandom_range(0, 49) == 0) begin
          rq[i] = 1'b0;
        end
      end else if (gen_mode == 2 && !rq[i]) begin
        arm(i, 1'b0);
      end
    end
    req = rq; req_t = rq_t; req_a_t = ra_t; req_b_t = rb_t;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ra[i];
      req_b[i*WIDTH +: WIDTH] = rb[i];
    end
    rst = rst_drv;

    // multiplier: stale result on the first cycle after start, garbage while busy
    m_done = last_done; m_product = last_prod; m_product_t = last_t; m_done_t = last_dt;
    if (op_valid) begin
      k = cyc - op_s;
      if (!op_stuck && k >= op_d) begin
        m_done = 1'b1; m_product = op_prod; m_product_t = op_t; m_done_t = op_dt;
      end else if (k >= 2) begin
        m_done = 1'b0; m_product = {$urandom, $urandom};
        m_product_t = 1'($urandom_range(0, 1)); m_done_t = 1'b0;
      end
    end

    @(negedge clk);
    issue_c  = tx_valid && (cyc == tx_s);
    resp_c   = tx_valid && (cyc == tx_r);
    exp_busy = tx_valid && (cyc >= tx_s) && (cyc <= tx_r);

    expect_eq("gnt", 64'(gnt), issue_c ? (64'(1) << tx_w) : 64'(0));
    expect_eq("m_start", 64'(m_start), 64'(issue_c));
    expect_eq("busy", 64'(busy), 64'(exp_busy));
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);

    if (issue_c) begin
      expect_eq("gnt_t", 64'(gnt_t), 64'(tx_gt));
      expect_eq("m_start_t", 64'(m_start_t), 64'(tx_gt));
      expect_eq("m_multiplier", 64'(m_multiplier), 64'(tx_a));
      expect_eq("m_multiplier_t", 64'(m_multiplier_t), 64'(tx_at | tx_gt));
      expect_eq("m_multiplicand", 64'(m_multiplicand), 64'(tx_b));
      expect_eq("m_multiplicand_t", 64'(m_multiplicand_t), 64'(tx_bt | tx_gt));
      if (op_valid) begin
        if (!op_stuck) begin
          last_done = 1; last_prod = op_prod; last_t = op_t; last_dt = op_dt;
        end else begin
          last_done = 0;
        end
      end
      op_valid = 1; op_s = cyc; op_d = tx_d; op_stuck = tx_stuck; op_dt = tx_dt;
      op_prod  = 64'(m_multiplier) * 64'(m_multiplicand);
      op_t     = m_multiplier_t | m_multiplicand_t;
      rq[tx_w] = 1'b0;
    end

    expect_eq("rsp_valid", 64'(rsp_valid), resp_c ? (64'(1) << tx_w) : 64'(0));
    if (resp_c) begin
      if (tx_stuck) begin
        expect_eq("rsp_product", 64'(rsp_product), 64'(0));
        expect_eq("rsp_product_t", 64'(rsp_product_t), 64'(tx_gt));
        expect_eq("rsp_valid_t", 64'(rsp_valid_t), 64'(tx_gt));
        expect_eq("rsp_err", 64'(rsp_err), 64'(1));
        exp_p = '0;
      end else begin
        exp_p = 64'(tx_a) * 64'(tx_b);
        expect_eq("rsp_product", 64'(rsp_product), exp_p);
        expect_eq("rsp_product_t", 64'(rsp_product_t), 64'(tx_at | tx_bt | tx_gt));
        expect_eq("rsp_valid_t", 64'(rsp_valid_t), 64'(tx_dt | tx_gt));
        expect_eq("rsp_err", 64'(rsp_err), 64'(0));
      end
      hold_val = exp_p;
      hold_cyc = cyc + 1;
    end else if (cyc == hold_cyc) begin
      expect_eq("rsp_product_hold", 64'(rsp_product), hold_val);
    end

    if (tx_valid) begin
      if (resp_c) tx_valid = 0;
    end else if (rst_drv && rq != '0) begin
      w        = rr_pick(rq, ptr_m);
      tx_valid = 1;
      tx_w     = w;
      tx_s     = cyc + 1;
      tx_gt    = |(rq & rq_t);
      tx_a     = ra[w]; tx_b = rb[w]; tx_at = ra_t[w]; tx_bt = rb_t[w];
      tx_d     = (cfg_d == 0) ? int'($urandom_range(1, 5)) : cfg_d;
      tx_stuck = cfg_stuck;
      tx_dt    = cfg_dt_rand && ($urandom_range(0, 3) == 0);
      if (tx_stuck) begin
`ifdef MULT_ARB_TIMEOUT_EN
        tx_r = tx_s + TIMEOUT + 2;
`else
        tx_r = NEVER;
`endif
      end else begin
        qual = (tx_d > 2) ? tx_s + tx_d : tx_s + 2;
        tx_r = qual + 1;
      end
      ptr_m = (w + 1) % NREQ;
    end

    if (!rst_drv) begin
      tx_valid = 0; ptr_m = 0; op_valid = 0; hold_cyc = -1;
      last_done = 0; last_prod = '0; last_t = 0; last_dt = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    tick();
    rst_drv = 1'b1;
  endtask

  int seq_exp [5] = '{0, 1, 2, 3, 0};
  int guard;

  initial begin
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    rst = 1'b0; req = '0; req_t = '0; req_a = '0; req_b = '0; req_a_t = '0; req_b_t = '0;
    m_product = '0; m_product_t = 1'b0; m_done = 1'b0; m_done_t = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // reset state
    expect_eq("rst_busy", 64'(busy), 64'(0));
    expect_eq("rst_gnt", 64'(gnt), 64'(0));
    expect_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    expect_eq("rst_rsp_product", 64'(rsp_product), 64'(0));
    expect_eq("rst_taints", 64'({gnt_t, rsp_valid_t, rsp_product_t, m_start_t,
                                m_multiplier_t, m_multiplicand_t}), 64'(0));
    expect_eq("rst_m_ops", 64'({m_multiplier, m_multiplicand}), 64'(0));
    expect_eq("rst_err", 64'(rsp_err), 64'(0));

    // single request, 3 * 5
    gen_mode = 0; cfg_d = 3;
    set_req(1, 3, 5, 0, 0, 0);
    repeat (10) tick();

    // all requesters asking continuously from pointer 0
    do_reset();
    gnt_log.delete();
    gen_mode = 2;
    guard = 0;
    while (gnt_log.size() < 5 && guard < 200) begin tick(); guard++; end
    expect_eq("rr_grant_count", 64'(gnt_log.size() >= 5), 64'(1));
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      expect_eq($sformatf("rr_order_%0d", i), 64'(gnt_log[i]), 64'(seq_exp[i]));
    gen_mode = 0; rq = '0;
    repeat (12) tick();

    // operand-A taint only
    set_req(2, 32'h1234, 32'h77, 0, 1, 0);
    repeat (10) tick();

    // control-flow taint from a losing requester
    do_reset();
    gnt_log.delete();
    set_req(0, 11, 13, 0, 0, 0);
    set_req(3, 17, 19, 1, 0, 0);
    repeat (20) tick();
    expect_eq("ctl_taint_first_grant", 64'((gnt_log.size() > 0) ? gnt_log[0] : -1), 64'(0));

    // reset during WAIT, then fresh requests
    do_reset();
    cfg_d = 5;
    set_req(1, 7, 9, 0, 0, 0);
    repeat (3) tick();
    rq = '0;
    do_reset();
    expect_eq("midrst_busy", 64'(busy), 64'(0));
    gnt_log.delete();
    set_req(0, 21, 2, 0, 0, 0);
    set_req(2, 5, 6, 0, 0, 0);
    repeat (20) tick();
    expect_eq("midrst_grants", 64'(gnt_log.size()), 64'(2));
    expect_eq("midrst_ptr0", 64'((gnt_log.size() > 0) ? gnt_log[0] : -1), 64'(0));

    // multiplier never completes
    do_reset();
    cfg_stuck = 1;
    set_req(3, 100, 200, 0, 0, 0);
`ifdef MULT_ARB_TIMEOUT_EN
    repeat (TIMEOUT + 10) tick();
    expect_eq("timeout_idle", 64'(busy), 64'(0));
`else
    repeat (150) tick();
    expect_eq("stuck_busy", 64'(busy), 64'(1));
`endif
    cfg_stuck = 0;
    rq = '0;
    do_reset();

    // randomized traffic with occasional resets
    gen_mode = 1; withdraw_en = 1; cfg_d = 0; cfg_dt_rand = 1;
    for (int n = 0; n < 4000; n++) begin
      rst_drv = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_drv = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
